vec_pair_writer: RTL and testbench

On-chip producer of 32-bit word pairs for the two host-to-FPGA FIFO write ports feeding the MAC datapath (`fifo_a` and `fifo_b`). It is the writer end of the FIFO interface that the MAC reads. It pushes `num_vecs` vectors of `vec_len` pairs each, using a counter or LFSR pattern, so the MAC pipeline can be exercised without host traffic. It is muxed onto the FIFO write ports in place of `user_w_write_32_a/b`, outside this block, and is controlled by Xillybus Lite registers.

---
 rtl/vec_writer_pkg.sv | 20 ++
 rtl/vec_pair_writer_if.sv | 14 +
 rtl/vec_pattern_gen.sv | 52 +++++
 rtl/vec_pair_writer.sv | 168 ++++++++++++++++
 tb/tb_vec_pair_writer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/vec_writer_pkg.sv
// Shared types and constants for the vec_pair_writer pattern source.
package vec_writer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic        MODE_CNT  = 1'b0;
    localparam logic        MODE_LFSR = 1'b1;

    // fifo_b carries the same word with its 16-bit halves exchanged
    function automatic logic [31:0] swap_halves(input logic [31:0] w);
        return {w[15:0], w[31:16]};
    endfunction

endpackage

// File: rtl/vec_pair_writer_if.sv
// Paired FIFO write port: lockstep enables, data and full flags for fifo_a/fifo_b.
interface vec_pair_writer_if #(
    parameter int unsigned DATA_W = 32
);
    logic              wren_a;
    logic              wren_b;
    logic [DATA_W-1:0] din_a;
    logic [DATA_W-1:0] din_b;
    logic              full_a;
    logic              full_b;

    modport master (output wren_a, wren_b, din_a, din_b, input full_a, full_b);
    modport slave  (input wren_a, wren_b, din_a, din_b, output full_a, full_b);
endinterface

// File: rtl/vec_pattern_gen.sv
// Counter / Galois-LFSR word generator; a zero LFSR seed is replaced by 1.
module vec_pattern_gen
    import vec_writer_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              bus_clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] seed,
    input  logic              mode,
    input  logic              advance,
    output logic [DATA_W-1:0] word
);

    logic [DATA_W-1:0] word_q, word_d;
    logic              mode_q, mode_d;

    // Next word: load seeds and latches mode, advance steps the selected pattern
    always_comb begin
        word_d = word_q;
        mode_d = mode_q;
        if (load) begin
            mode_d = mode;
            if (mode == MODE_LFSR && seed == '0) begin
                word_d = DATA_W'(1);
            end else begin
                word_d = seed;
            end
        end else if (advance) begin
            if (mode_q == MODE_CNT) begin
                word_d = word_q + DATA_W'(1);
            end else begin
                word_d = (word_q >> 1) ^ (word_q[0] ? DATA_W'(LFSR_POLY) : '0);
            end
        end
    end

    // Pattern state register
    always_ff @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            mode_q <= MODE_CNT;
        end else begin
            word_q <= word_d;
            mode_q <= mode_d;
        end
    end

    assign word = word_q;

endmodule

// File: rtl/vec_pair_writer.sv
// Test-pattern writer for the MAC input FIFO pair: num_vecs vectors of vec_len
// aligned pairs, one idle cycle between vectors.
// Optional: define VEC_WRITER_CHECKSUM_EN to add running XOR checksums of the
// accepted words on checksum_a / checksum_b.
module vec_pair_writer
    import vec_writer_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              bus_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [CNT_W-1:0]  vec_len,
    input  logic [CNT_W-1:0]  num_vecs,
    output logic              busy,
    output logic              done,
    output logic [31:0]       words_sent,
    vec_pair_writer_if.master fifo
`ifdef VEC_WRITER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum_a,
    output logic [DATA_W-1:0] checksum_b
`endif
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  vec_len_q, vec_len_d;
    logic [CNT_W-1:0]  num_vecs_q, num_vecs_d;
    logic [CNT_W-1:0]  pair_cnt_q, pair_cnt_d;
    logic [CNT_W-1:0]  vec_cnt_q, vec_cnt_d;
    logic [31:0]       words_q, words_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] word;

    logic start_ok_c;
    logic accept_c;
    logic last_pair_c;
    logic last_vec_c;

    assign start_ok_c  = (state_q == IDLE) && start;
    assign accept_c    = (state_q == RUN) && !fifo.full_a && !fifo.full_b;
    assign last_pair_c = (pair_cnt_q == vec_len_q - CNT_W'(1));
    assign last_vec_c  = (vec_cnt_q == num_vecs_q - CNT_W'(1));

    // Run sequencing: config latch, pair/vector counting, state transitions
    always_comb begin
        state_d    = state_q;
        vec_len_d  = vec_len_q;
        num_vecs_d = num_vecs_q;
        pair_cnt_d = pair_cnt_q;
        vec_cnt_d  = vec_cnt_q;
        words_d    = words_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    vec_len_d  = vec_len;
                    num_vecs_d = num_vecs;
                    pair_cnt_d = '0;
                    vec_cnt_d  = '0;
                    words_d    = '0;
                    state_d    = (vec_len == '0 || num_vecs == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept_c) begin
                    words_d = words_q + 32'(1);
                    if (last_pair_c) begin
                        pair_cnt_d = '0;
                        if (last_vec_c) begin
                            state_d = DONE;
                        end else begin
                            vec_cnt_d = vec_cnt_q + CNT_W'(1);
                            state_d   = GAP;
                        end
                    end else begin
                        pair_cnt_d = pair_cnt_q + CNT_W'(1);
                    end
                end
            end
            GAP:     state_d = RUN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // Control and status registers
    always_ff @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            vec_len_q  <= '0;
            num_vecs_q <= '0;
            pair_cnt_q <= '0;
            vec_cnt_q  <= '0;
            words_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_len_q  <= vec_len_d;
            num_vecs_q <= num_vecs_d;
            pair_cnt_q <= pair_cnt_d;
            vec_cnt_q  <= vec_cnt_d;
            words_q    <= words_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    vec_pattern_gen #(
        .DATA_W (DATA_W)
    ) u_gen (
        .bus_clk (bus_clk),
        .rst_n   (rst_n),
        .load    (start_ok_c),
        .seed    (seed),
        .mode    (mode),
        .advance (accept_c),
        .word    (word)
    );

    // Both FIFOs are written together or not at all so pairs stay aligned
    assign fifo.wren_a = accept_c;
    assign fifo.wren_b = accept_c;
    assign fifo.din_a  = word;
    assign fifo.din_b  = swap_halves(word);
    assign busy        = busy_q;
    assign done        = done_q;
    assign words_sent  = words_q;

`ifdef VEC_WRITER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_a_q, csum_a_d;
    logic [DATA_W-1:0] csum_b_q, csum_b_d;

    // Running XOR of accepted words, cleared by an accepted start
    always_comb begin
        csum_a_d = csum_a_q;
        csum_b_d = csum_b_q;
        if (start_ok_c) begin
            csum_a_d = '0;
            csum_b_d = '0;
        end else if (accept_c) begin
            csum_a_d = csum_a_q ^ word;
            csum_b_d = csum_b_q ^ swap_halves(word);
        end
    end

    // Checksum registers
    always_ff @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_a_q <= '0;
            csum_b_q <= '0;
        end else begin
            csum_a_q <= csum_a_d;
            csum_b_q <= csum_b_d;
        end
    end

    assign checksum_a = csum_a_q;
    assign checksum_b = csum_b_q;
`endif

endmodule

// File: tb/tb_vec_pair_writer.sv
// Bench for vec_pair_writer: directed table, reset corner case, randomized runs.
module tb_vec_pair_writer;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;
    localparam logic [31:0] POLY   = 32'h8020_0003;

    logic        bus_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start   = 1'b0;
    logic        mode    = 1'b0;
    logic [31:0] seed    = '0;
    logic [15:0] vec_len = '0;
    logic [15:0] num_vecs = '0;
    logic        busy;
    logic        done;
    logic [31:0] words_sent;
`ifdef VEC_WRITER_CHECKSUM_EN
    logic [31:0] checksum_a;
    logic [31:0] checksum_b;
`endif

    vec_pair_writer_if #(.DATA_W(DATA_W)) fifo ();

    vec_pair_writer #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .bus_clk    (bus_clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .seed       (seed),
        .vec_len    (vec_len),
        .num_vecs   (num_vecs),
        .busy       (busy),
        .done       (done),
        .words_sent (words_sent),
        .fifo       (fifo)
`ifdef VEC_WRITER_CHECKSUM_EN
        ,
        .checksum_a (checksum_a),
        .checksum_b (checksum_b)
`endif
    );

    always #5 bus_clk = ~bus_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] swap16(input logic [31:0] w);
        return {w[15:0], w[31:16]};
    endfunction

    // Reference pattern: counter is seed+k; LFSR is a Galois right shift
    function automatic logic [31:0] lfsr_step(input logic [31:0] w);
        return w[0] ? ((w >> 1) ^ POLY) : (w >> 1);
    endfunction

    // One complete run, checked cycle by cycle against a count-based model
    task automatic run(input string tag, input logic m, input logic [31:0] sd,
                       input int vl, input int nv, input logic [31:0] stall_b,
                       input bit rnd_full, input bit mid_start,
                       output logic [31:0] first_a, output logic [31:0] last_a,
                       output int sent);
        logic [31:0] exp_q[$];
        logic [31:0] w, csa, csb;
        int total, n, phase;
        bit gap, ended, exp_wr, fa, fb;
        total = vl * nv;
        w = (m && sd == '0) ? 32'd1 : sd;
        for (int i = 0; i < total; i++) begin
            exp_q.push_back(m ? w : sd + 32'(i));
            w = lfsr_step(w);
        end
        @(posedge bus_clk); #1;
        mode = m; seed = sd; vec_len = 16'(vl); num_vecs = 16'(nv); start = 1'b1;
        @(posedge bus_clk); #1;
        start = 1'b0; mode = ~m; seed = ~sd; vec_len = 16'(vl + 1); num_vecs = 16'(nv + 1);
        n = 0; gap = 0; ended = 0; phase = (total == 0) ? 1 : 0;
        first_a = '0; last_a = '0; csa = '0; csb = '0;
        for (int cyc = 1; cyc <= 40 * total + 40 && !ended; cyc++) begin
            fa = rnd_full && ($urandom_range(0, 3) == 0);
            fb = (rnd_full && ($urandom_range(0, 3) == 0)) || (cyc < 32 && stall_b[cyc]);
            fifo.full_a = fa;
            fifo.full_b = fb;
            start = mid_start && (cyc == 2);
            @(negedge bus_clk);
            exp_wr = (phase == 0) && !gap && !fa && !fb;
            chk({tag, " wren_a"}, 32'(fifo.wren_a), 32'(exp_wr));
            chk({tag, " wren_b"}, 32'(fifo.wren_b), 32'(exp_wr));
            if (phase == 0) begin
                chk({tag, " din_a"}, fifo.din_a, exp_q[n]);
                chk({tag, " din_b"}, fifo.din_b, swap16(exp_q[n]));
            end
            chk({tag, " done"}, 32'(done), 32'(phase == 1));
            chk({tag, " busy"}, 32'(busy), 32'(phase != 2));
            chk({tag, " words_sent"}, words_sent, 32'(n));
            if (exp_wr) begin
                if (n == 0) first_a = fifo.din_a;
                last_a = fifo.din_a;
                csa = csa ^ exp_q[n];
                csb = csb ^ swap16(exp_q[n]);
                n++;
                if (n == total) phase = 1;
                else gap = (n % vl == 0);
            end else if (phase == 0) begin
                gap = 0;
            end else if (phase == 1) begin
                phase = 2;
            end else begin
                ended = 1;
            end
            if (!ended) begin
                @(posedge bus_clk); #1;
            end
        end
        fifo.full_a = 1'b0;
        fifo.full_b = 1'b0;
        start = 1'b0;
        if (!ended) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d pairs want %0d, run never finished", tag, n, total);
        end
        sent = int'(words_sent);
`ifdef VEC_WRITER_CHECKSUM_EN
        chk({tag, " checksum_a"}, checksum_a, csa);
        chk({tag, " checksum_b"}, checksum_b, csb);
`endif
    endtask

    typedef struct {
        logic        m;
        logic [31:0] sd;
        int          vl;
        int          nv;
        logic [31:0] stall;
        bit          mid;
        logic [31:0] first;
        logic [31:0] last;
        int          total;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [31:0] f, l;
        int s;
        fifo.full_a = 1'b0;
        fifo.full_b = 1'b0;

        tbl[0] = '{1'b0, 32'h10,       4, 1, 32'h0,  1'b0, 32'h10,       32'h13,       4};
        tbl[1] = '{1'b0, 32'h10,       4, 1, 32'h38, 1'b0, 32'h10,       32'h13,       4};
        tbl[2] = '{1'b1, 32'h0,        2, 1, 32'h0,  1'b0, 32'h1,        32'h80200003, 2};
        tbl[3] = '{1'b0, 32'h0,        2, 3, 32'h0,  1'b0, 32'h0,        32'h5,        6};
        tbl[4] = '{1'b0, 32'h55,       0, 3, 32'h0,  1'b0, 32'h0,        32'h0,        0};
        tbl[5] = '{1'b0, 32'h10,       4, 2, 32'h0,  1'b1, 32'h10,       32'h17,       8};
        tbl[6] = '{1'b0, 32'hFFFFFFFE, 4, 1, 32'h0,  1'b0, 32'hFFFFFFFE, 32'h1,        4};
        tbl[7] = '{1'b0, 32'h7,        5, 0, 32'h0,  1'b0, 32'h0,        32'h0,        0};

        // Reset state
        repeat (3) @(posedge bus_clk);
        #1;
        chk("rst wren_a", 32'(fifo.wren_a), 32'h0);
        chk("rst wren_b", 32'(fifo.wren_b), 32'h0);
        chk("rst din_a", fifo.din_a, 32'h0);
        chk("rst din_b", fifo.din_b, 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst done", 32'(done), 32'h0);
        chk("rst words_sent", words_sent, 32'h0);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            string tag;
            tag = $sformatf("tbl%0d", i);
            run(tag, tbl[i].m, tbl[i].sd, tbl[i].vl, tbl[i].nv, tbl[i].stall,
                1'b0, tbl[i].mid, f, l, s);
            chk({tag, " first"}, f, tbl[i].first);
            chk({tag, " last"}, l, tbl[i].last);
            chk({tag, " total"}, 32'(s), 32'(tbl[i].total));
        end

        // Asynchronous reset in the middle of an 8-pair run
        @(posedge bus_clk); #1;
        mode = 1'b0; seed = 32'h100; vec_len = 16'd8; num_vecs = 16'd1; start = 1'b1;
        @(posedge bus_clk); #1;
        start = 1'b0;
        repeat (3) @(posedge bus_clk);
        #1;
        chk("mid words_sent", words_sent, 32'd3);
        chk("mid din_a", fifo.din_a, 32'h103);
        chk("mid busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst wren_a", 32'(fifo.wren_a), 32'h0);
        chk("arst din_a", fifo.din_a, 32'h0);
        chk("arst din_b", fifo.din_b, 32'h0);
        chk("arst busy", 32'(busy), 32'h0);
        chk("arst done", 32'(done), 32'h0);
        chk("arst words_sent", words_sent, 32'h0);
        @(negedge bus_clk);
        rst_n = 1'b1;
        run("restart", 1'b0, 32'h100, 8, 1, 32'h0, 1'b0, 1'b0, f, l, s);
        chk("restart first", f, 32'h100);
        chk("restart total", 32'(s), 32'd8);

        // Randomized runs with random back-pressure on both FIFOs
        for (int r = 0; r < 24; r++) begin
            logic        rm;
            logic [31:0] rs;
            int          rvl, rnv;
            bit          rmid;
            rm   = 1'($urandom_range(0, 1));
            rs   = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            rvl  = $urandom_range(0, 5);
            rnv  = $urandom_range(0, 4);
            rmid = (rvl * rnv >= 2) && ($urandom_range(0, 1) == 1);
            run($sformatf("rnd%0d", r), rm, rs, rvl, rnv, 32'h0, 1'b1, rmid, f, l, s);
            chk($sformatf("rnd%0d total", r), 32'(s), 32'(rvl * rnv));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
